// File: rtl/reorder_buffer.sv
// ============================================================================
// reorder_buffer : circular in-order ROB with CDB capture, commit, flush
// Revision 1.0
// ============================================================================
`default_nettype none

module reorder_buffer #(
    parameter int TAG_W = 4,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic             issue_writes,
    input  logic [4:0]       issue_dest,
    input  logic             issue_is_branch,
    output logic             issue_ready,
    output logic [TAG_W-1:0] issue_ROB,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_ROB,
    input  logic [XLEN-1:0]  cdb_value,
    input  logic             cdb_mispredict,
    input  logic [XLEN-1:0]  cdb_target,
    input  logic [TAG_W-1:0] q_j_ROB,
    input  logic [TAG_W-1:0] q_k_ROB,
    output logic             q_j_ready,
    output logic             q_k_ready,
    output logic [XLEN-1:0]  q_j_value,
    output logic [XLEN-1:0]  q_k_value,
    output logic             commit_valid,
    output logic [TAG_W-1:0] commit_ROB,
    output logic [4:0]       commit_dest,
    output logic             RegWrite,
    output logic [XLEN-1:0]  commit_value,
    output logic             flush,
    output logic [XLEN-1:0]  flush_pc
);

    localparam int               DEPTH     = 1 << TAG_W;
    localparam logic [TAG_W-1:0] MAX_TAG   = '1;
    localparam logic [TAG_W-1:0] FIRST_TAG = TAG_W'(1);

    logic             entry_busy       [DEPTH];
    logic             entry_ready      [DEPTH];
    logic             entry_writes     [DEPTH];
    logic             entry_is_branch  [DEPTH];
    logic             entry_mispredict [DEPTH];
    logic [4:0]       entry_dest       [DEPTH];
    logic [XLEN-1:0]  entry_value      [DEPTH];
    logic [XLEN-1:0]  entry_target     [DEPTH];

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W-1:0] count;

    logic alloc;
    logic cdb_take;
    logic do_flush;

    // Tag 0 means "no dependency", so pointers skip it on wrap.
    function automatic logic [TAG_W-1:0] next_ptr(input logic [TAG_W-1:0] p);
        return (p == MAX_TAG) ? FIRST_TAG : p + FIRST_TAG;
    endfunction

    function automatic logic [XLEN:0] lookup(input logic [TAG_W-1:0] t);
        if (t == '0)
            return {1'b1, {XLEN{1'b0}}};
        else if (entry_ready[t])
            return {1'b1, entry_value[t]};
        else if (cdb_valid && !flush && cdb_ROB == t)
            return {1'b1, cdb_value};
        else
            return '0;
    endfunction

    assign issue_ready  = (count != MAX_TAG) && !flush;
    assign issue_ROB    = tail;
    assign alloc        = issue_valid && issue_ready;
    assign cdb_take     = cdb_valid && !flush && (cdb_ROB != '0) && entry_busy[cdb_ROB];

    assign commit_valid = entry_busy[head] && entry_ready[head] && !flush;
    assign commit_ROB   = head;
    assign commit_dest  = entry_dest[head];
    assign commit_value = entry_value[head];
    assign RegWrite     = commit_valid && entry_writes[head] && !entry_is_branch[head];
    assign do_flush     = commit_valid && entry_is_branch[head] && entry_mispredict[head];

    assign {q_j_ready, q_j_value} = lookup(q_j_ROB);
    assign {q_k_ready, q_k_value} = lookup(q_k_ROB);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_busy[i]       <= 1'b0;
                entry_ready[i]      <= 1'b0;
                entry_writes[i]     <= 1'b0;
                entry_is_branch[i]  <= 1'b0;
                entry_mispredict[i] <= 1'b0;
                entry_dest[i]       <= '0;
                entry_value[i]      <= '0;
                entry_target[i]     <= '0;
            end
            head     <= FIRST_TAG;
            tail     <= FIRST_TAG;
            count    <= '0;
            flush    <= 1'b0;
            flush_pc <= '0;
        end else begin
            flush <= 1'b0;
            if (do_flush) begin
                // Mispredicted branch retires: squash everything younger.
                for (int i = 0; i < DEPTH; i++) begin
                    entry_busy[i]       <= 1'b0;
                    entry_ready[i]      <= 1'b0;
                    entry_writes[i]     <= 1'b0;
                    entry_is_branch[i]  <= 1'b0;
                    entry_mispredict[i] <= 1'b0;
                end
                head     <= FIRST_TAG;
                tail     <= FIRST_TAG;
                count    <= '0;
                flush    <= 1'b1;
                flush_pc <= entry_target[head];
            end else begin
                if (cdb_take) begin
                    entry_ready[cdb_ROB]      <= 1'b1;
                    entry_value[cdb_ROB]      <= cdb_value;
                    entry_mispredict[cdb_ROB] <= cdb_mispredict;
                    entry_target[cdb_ROB]     <= cdb_target;
                end
                if (alloc) begin
                    entry_busy[tail]       <= 1'b1;
                    entry_ready[tail]      <= 1'b0;
                    entry_writes[tail]     <= issue_writes;
                    entry_dest[tail]       <= issue_dest;
                    entry_is_branch[tail]  <= issue_is_branch;
                    entry_mispredict[tail] <= 1'b0;
                    tail                   <= next_ptr(tail);
                end
                if (commit_valid) begin
                    entry_busy[head]  <= 1'b0;
                    entry_ready[head] <= 1'b0;
                    head              <= next_ptr(head);
                end
                case ({alloc, commit_valid})
                    2'b10:   count <= count + FIRST_TAG;
                    2'b01:   count <= count - FIRST_TAG;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// ============================================================================
// tb_reorder_buffer : directed self-checking bench for reorder_buffer
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_writes, issue_is_branch;
    logic [4:0]  issue_dest;
    logic        issue_ready;
    logic [3:0]  issue_ROB;
    logic        cdb_valid, cdb_mispredict;
    logic [3:0]  cdb_ROB;
    logic [31:0] cdb_value, cdb_target;
    logic [3:0]  q_j_ROB, q_k_ROB;
    logic        q_j_ready, q_k_ready;
    logic [31:0] q_j_value, q_k_value;
    logic        commit_valid, RegWrite, flush;
    logic [3:0]  commit_ROB;
    logic [4:0]  commit_dest;
    logic [31:0] commit_value, flush_pc;

    int n_cmp = 0;
    int n_err = 0;

    reorder_buffer #(.TAG_W(4), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_writes(issue_writes),
        .issue_dest(issue_dest), .issue_is_branch(issue_is_branch),
        .issue_ready(issue_ready), .issue_ROB(issue_ROB),
        .cdb_valid(cdb_valid), .cdb_ROB(cdb_ROB), .cdb_value(cdb_value),
        .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
        .q_j_ROB(q_j_ROB), .q_k_ROB(q_k_ROB),
        .q_j_ready(q_j_ready), .q_k_ready(q_k_ready),
        .q_j_value(q_j_value), .q_k_value(q_k_value),
        .commit_valid(commit_valid), .commit_ROB(commit_ROB),
        .commit_dest(commit_dest), .RegWrite(RegWrite),
        .commit_value(commit_value), .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        issue_valid = 0; issue_writes = 0; issue_dest = 0; issue_is_branch = 0;
        cdb_valid = 0; cdb_ROB = 0; cdb_value = 0; cdb_mispredict = 0; cdb_target = 0;
        q_j_ROB = 0; q_k_ROB = 0;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL rst_issue_ready: got %b want 1", issue_ready); end
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL rst_commit_valid: got %b want 0", commit_valid); end
        n_cmp++; if (flush !== 1'b0 || flush_pc !== 32'h0) begin n_err++; $display("FAIL rst_flush: got %b/%h want 0/0", flush, flush_pc); end
        n_cmp++; if (issue_ROB !== 4'd1) begin n_err++; $display("FAIL rst_issue_rob: got %0d want 1", issue_ROB); end
        n_cmp++; if (dut.count !== 4'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", dut.count); end
    endtask

    task automatic test_issue();
        issue_writes = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            issue_valid = 1'b1;
            issue_dest  = 5'(4 + i);
            #1;
            n_cmp++; if (issue_ROB !== 4'(i)) begin n_err++; $display("FAIL issue_tag: got %0d want %0d", issue_ROB, i); end
            step();
        end
        issue_valid = 1'b0;
        #1;
        n_cmp++; if (dut.count !== 4'd3) begin n_err++; $display("FAIL issue_count: got %0d want 3", dut.count); end
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL issue_no_commit: got %b want 0", commit_valid); end
    endtask

    task automatic test_cdb_commit();
        cdb_valid = 1'b1; cdb_ROB = 4'd2; cdb_value = 32'hAA;
        step();
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL cdb_head_wait: got %b want 0", commit_valid); end
        cdb_ROB = 4'd1; cdb_value = 32'h55;
        step();
        cdb_valid = 1'b0;
        #1;
        n_cmp++; if (commit_valid !== 1'b1 || commit_ROB !== 4'd1) begin n_err++; $display("FAIL commit1: got v=%b tag=%0d want v=1 tag=1", commit_valid, commit_ROB); end
        n_cmp++; if (commit_dest !== 5'd5 || commit_value !== 32'h55 || RegWrite !== 1'b1) begin n_err++; $display("FAIL commit1_data: got d=%0d val=%h rw=%b want d=5 val=55 rw=1", commit_dest, commit_value, RegWrite); end
        step();
        n_cmp++; if (commit_valid !== 1'b1 || commit_ROB !== 4'd2 || commit_value !== 32'hAA || commit_dest !== 5'd6) begin n_err++; $display("FAIL commit2: got v=%b tag=%0d val=%h d=%0d want 1/2/aa/6", commit_valid, commit_ROB, commit_value, commit_dest); end
        step();
        n_cmp++; if (commit_valid !== 1'b0 || commit_ROB !== 4'd3) begin n_err++; $display("FAIL head_tag3: got v=%b tag=%0d want v=0 tag=3", commit_valid, commit_ROB); end
        n_cmp++; if (dut.count !== 4'd1) begin n_err++; $display("FAIL count_after_commit: got %0d want 1", dut.count); end
    endtask

    task automatic test_full();
        do_reset();
        issue_writes = 1'b1;
        for (int i = 0; i < 15; i++) begin
            issue_valid = 1'b1;
            issue_dest  = 5'(i);
            step();
        end
        n_cmp++; if (issue_ready !== 1'b0 || dut.count !== 4'd15) begin n_err++; $display("FAIL full: got rdy=%b count=%0d want 0/15", issue_ready, dut.count); end
        step();
        n_cmp++; if (dut.count !== 4'd15 || issue_ROB !== 4'd1) begin n_err++; $display("FAIL full_hold: got count=%0d tail=%0d want 15/1", dut.count, issue_ROB); end
        issue_valid = 1'b0;
        cdb_valid = 1'b1; cdb_ROB = 4'd1; cdb_value = 32'h11;
        step();
        cdb_valid = 1'b0;
        #1;
        n_cmp++; if (commit_valid !== 1'b1 || issue_ready !== 1'b0) begin n_err++; $display("FAIL full_commit_same: got cv=%b rdy=%b want 1/0", commit_valid, issue_ready); end
        step();
        n_cmp++; if (issue_ready !== 1'b1 || issue_ROB !== 4'd1) begin n_err++; $display("FAIL wrap_ready: got rdy=%b tag=%0d want 1/1", issue_ready, issue_ROB); end
        issue_valid = 1'b1; issue_dest = 5'd9;
        step();
        issue_valid = 1'b0;
        #1;
        n_cmp++; if (dut.count !== 4'd15 || issue_ROB !== 4'd2) begin n_err++; $display("FAIL wrap_alloc: got count=%0d tail=%0d want 15/2", dut.count, issue_ROB); end
    endtask

    task automatic test_bypass();
        q_j_ROB = 4'd4; q_k_ROB = 4'd0;
        cdb_valid = 1'b1; cdb_ROB = 4'd4; cdb_value = 32'h123;
        #1;
        n_cmp++; if (q_j_ready !== 1'b1 || q_j_value !== 32'h123) begin n_err++; $display("FAIL bypass_j: got %b/%h want 1/123", q_j_ready, q_j_value); end
        n_cmp++; if (q_k_ready !== 1'b1 || q_k_value !== 32'h0) begin n_err++; $display("FAIL tag0_k: got %b/%h want 1/0", q_k_ready, q_k_value); end
        q_k_ROB = 4'd5;
        #1;
        n_cmp++; if (q_k_ready !== 1'b0 || q_k_value !== 32'h0) begin n_err++; $display("FAIL notready_k: got %b/%h want 0/0", q_k_ready, q_k_value); end
        step();
        cdb_valid = 1'b0;
        #1;
        n_cmp++; if (q_j_ready !== 1'b1 || q_j_value !== 32'h123) begin n_err++; $display("FAIL stored_j: got %b/%h want 1/123", q_j_ready, q_j_value); end
        q_j_ROB = 4'd0; q_k_ROB = 4'd0;
    endtask

    task automatic test_mispredict();
        do_reset();
        issue_valid = 1'b1; issue_is_branch = 1'b1; issue_writes = 1'b1; issue_dest = 5'd1;
        step();
        issue_is_branch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue_dest = 5'(10 + i);
            step();
        end
        issue_valid = 1'b0;
        cdb_valid = 1'b1; cdb_ROB = 4'd1; cdb_value = 32'h0;
        cdb_mispredict = 1'b1; cdb_target = 32'h400;
        step();
        cdb_valid = 1'b0; cdb_mispredict = 1'b0;
        issue_valid = 1'b1; issue_dest = 5'd3;
        #1;
        n_cmp++; if (commit_valid !== 1'b1 || commit_ROB !== 4'd1 || RegWrite !== 1'b0) begin n_err++; $display("FAIL br_commit: got v=%b tag=%0d rw=%b want 1/1/0", commit_valid, commit_ROB, RegWrite); end
        n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL br_flush_early: got %b want 0", flush); end
        step();
        issue_valid = 1'b0;
        cdb_valid = 1'b1; cdb_ROB = 4'd2; cdb_value = 32'h77;
        #1;
        n_cmp++; if (flush !== 1'b1 || flush_pc !== 32'h400) begin n_err++; $display("FAIL flush_pulse: got %b/%h want 1/400", flush, flush_pc); end
        n_cmp++; if (issue_ready !== 1'b0 || commit_valid !== 1'b0) begin n_err++; $display("FAIL flush_block: got rdy=%b cv=%b want 0/0", issue_ready, commit_valid); end
        step();
        cdb_valid = 1'b0;
        q_j_ROB = 4'd2;
        #1;
        n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL flush_one_cycle: got %b want 0", flush); end
        n_cmp++; if (dut.count !== 4'd0 || issue_ROB !== 4'd1 || issue_ready !== 1'b1) begin n_err++; $display("FAIL post_flush: got count=%0d tag=%0d rdy=%b want 0/1/1", dut.count, issue_ROB, issue_ready); end
        n_cmp++; if (q_j_ready !== 1'b0) begin n_err++; $display("FAIL flush_cdb_ignored: got %b want 0", q_j_ready); end
        q_j_ROB = 4'd0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue_valid = 1'b1; issue_writes = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue_dest = 5'(20 + i);
            step();
        end
        issue_valid = 1'b0;
        cdb_valid = 1'b1; cdb_ROB = 4'd1; cdb_value = 32'hBEEF;
        step();
        cdb_valid = 1'b0;
        #1;
        n_cmp++; if (commit_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset_commit: got %b want 1", commit_valid); end
        #1;
        reset = 1'b1;
        #1;
        n_cmp++; if (commit_valid !== 1'b0 || issue_ready !== 1'b1 || flush !== 1'b0) begin n_err++; $display("FAIL async_reset: got cv=%b rdy=%b fl=%b want 0/1/0", commit_valid, issue_ready, flush); end
        n_cmp++; if (issue_ROB !== 4'd1 || dut.count !== 4'd0) begin n_err++; $display("FAIL async_reset_ptr: got tag=%0d count=%0d want 1/0", issue_ROB, dut.count); end
        step();
        reset = 1'b0;
        issue_valid = 1'b1; issue_dest = 5'd2;
        #1;
        n_cmp++; if (issue_ROB !== 4'd1) begin n_err++; $display("FAIL post_reset_tag: got %0d want 1", issue_ROB); end
        step();
        issue_valid = 1'b0;
        #1;
        n_cmp++; if (dut.count !== 4'd1 || issue_ROB !== 4'd2) begin n_err++; $display("FAIL post_reset_alloc: got count=%0d tail=%0d want 1/2", dut.count, issue_ROB); end
    endtask

    initial begin
        test_reset();
        test_issue();
        test_cdb_commit();
        test_full();
        test_bypass();
        test_mispredict();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
